uart_rx_controller: RTL

- Receive-side bit-level controller for the UART RX path.
- Synchronises and oversamples the serial line, detects the start bit, shifts in 8 data bits LSB-first, checks the stop bit and presents the received byte through a one-entry valid/ready holding register.
- Drives the enable and clear inputs of receive_frame_detector and consumes its receive_done output.
- Frame format is fixed: 1 start bit, 8 data bits, no parity, 1 stop bit (10 bit periods).

---
 rtl/uart_rx_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_controller.sv
// UART receive bit-level controller: synchronises and oversamples rxd, frames
// 1 start + 8 data (LSB first) + 1 stop bit, steps the external frame counter
// and presents each good byte through a one-entry valid/ready holding register.
`timescale 1ns/1ps

module uart_rx_controller #(
  parameter int OVERSAMPLE  = 16, // baud_tick pulses per bit period; even, >= 4
  parameter int SYNC_STAGES = 2   // synchroniser depth on rxd; >= 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic       receive_done,
  input  logic       rx_ready,
  output logic       receive_frame_counter_en,
  output logic       receive_frame_counter_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       framing_error,
  output logic       overrun_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_BIT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [TW-1:0]          tick_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_q;
  logic                   stop_bit;
  logic                   armed;
  logic                   clear_hold;

  // Synchronise the asynchronous serial line; resets to the idle (high) level.
  always_ff @(posedge pclk) begin
    if (preset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxd_s   = sync_q[SYNC_STAGES-1];
  assign rx_busy = (state != IDLE);

  // Receive FSM, frame-counter handshake and holding register.
  // NOTE: every register here uses <= so all reads see the pre-edge values;
  // later assignments in the same block override the per-cycle defaults.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state                       <= IDLE;
      tick_cnt                    <= '0;
      bit_idx                     <= '0;
      shift_q                     <= '0;
      stop_bit                    <= 1'b0;
      armed                       <= 1'b0;
      rx_data                     <= '0;
      rx_valid                    <= 1'b0;
      framing_error               <= 1'b0;
      overrun_error               <= 1'b0;
      receive_frame_counter_en    <= 1'b0;
      receive_frame_counter_clear <= 1'b1;
      clear_hold                  <= 1'b1;
    end else begin
      // Single-cycle pulses default low; clear stretches one cycle past reset.
      receive_frame_counter_en    <= 1'b0;
      framing_error               <= 1'b0;
      overrun_error               <= 1'b0;
      receive_frame_counter_clear <= clear_hold;
      clear_hold                  <= 1'b0;

      if (rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (baud_tick) begin
            if (rxd_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              tick_cnt <= '0;
              state    <= START;
            end
          end
        end

        START: begin
          if (baud_tick) begin
            if (tick_cnt == HALF_BIT) begin
              if (!rxd_s) begin
                receive_frame_counter_en <= 1'b1;
                tick_cnt                 <= '0;
                bit_idx                  <= '0;
                state                    <= DATA;
              end else begin
                state <= IDLE; // glitch, not a start bit
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (baud_tick) begin
            if (tick_cnt == LAST_TICK) begin
              shift_q                  <= {rxd_s, shift_q[7:1]};
              receive_frame_counter_en <= 1'b1;
              tick_cnt                 <= '0;
              bit_idx                  <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (baud_tick) begin
            if (tick_cnt == LAST_TICK) begin
              stop_bit                 <= rxd_s;
              receive_frame_counter_en <= 1'b1;
              tick_cnt                 <= '0;
              state                    <= DONE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          if (receive_done) begin
            receive_frame_counter_clear <= 1'b1;
            state                       <= IDLE;
            // A low stop bit disarms so a held-low break cannot retrigger.
            armed                       <= stop_bit;
            if (!stop_bit) begin
              framing_error <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
            end else begin
              overrun_error <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
